// File: rtl/aemb_wb_arbiter.sv
// aemb_wb_arbiter
//
// Two-master, one-slave Wishbone arbiter. It lets the aeMB instruction port (iwb) and
// data port (dwb) share one unified 32-bit memory. Each transaction is granted to one
// master, and the slave acknowledge is routed back to that master. A grant-cycle
// watchdog ends any transaction the slave never acknowledges by raising the granted
// master's err.
//
// Parameters:
//   ASIZ  address width of both masters and the slave
//   TOUT  watchdog limit in grant cycles (1..255, 8-bit counter)
//
// Build option:
//   AEMB_WBARB_RR_EN  defined   -> round-robin on a tie (grant the master not served last)
//                     undefined -> fixed priority on a tie (dwb always wins)
//
// Ports:
//   sys_clk_i            clock, rising edge
//   sys_rst_i            asynchronous, active-low reset
//   iwb_adr_i/stb_i      instruction fetch request
//   iwb_dat_o/ack_o/err_o  fetch data, acknowledge, timeout
//   dwb_adr_i/dat_i/we_i/stb_i  data request (we = 1 store)
//   dwb_dat_o/ack_o/err_o  load data, acknowledge, timeout
//   xwb_adr_o/dat_o/we_o/stb_o  slave request
//   xwb_dat_i/ack_i      slave read data and acknowledge
//
// No data is registered here: slave-side request signals, ack and err are all
// combinational from the current grant state, the counter and the live inputs.

module aemb_wb_arbiter #(
    parameter int unsigned ASIZ = 16,
    parameter int unsigned TOUT = 255
) (
    input  logic            sys_clk_i,
    input  logic            sys_rst_i,

    input  logic [ASIZ-1:0] iwb_adr_i,
    input  logic            iwb_stb_i,
    output logic [31:0]     iwb_dat_o,
    output logic            iwb_ack_o,
    output logic            iwb_err_o,

    input  logic [ASIZ-1:0] dwb_adr_i,
    input  logic [31:0]     dwb_dat_i,
    input  logic            dwb_we_i,
    input  logic            dwb_stb_i,
    output logic [31:0]     dwb_dat_o,
    output logic            dwb_ack_o,
    output logic            dwb_err_o,

    output logic [ASIZ-1:0] xwb_adr_o,
    output logic [31:0]     xwb_dat_o,
    output logic            xwb_we_o,
    output logic            xwb_stb_o,
    input  logic [31:0]     xwb_dat_i,
    input  logic            xwb_ack_i
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntI = 2'd1,
        StGntD = 2'd2
    } fsm_e;

    typedef enum logic {
        LastI = 1'b0,
        LastD = 1'b1
    } last_e;

    // Last grant cycle before the watchdog fires.
    localparam logic [7:0] CntLim = 8'(TOUT - 1);

    fsm_e       fsm_q;
    last_e      last_q;
    logic [7:0] cnt_q;

    logic gnt_i;
    logic gnt_d;
    logic gnt_stb;
    logic wdog;
    logic tie_to_d;

    assign gnt_i = (fsm_q == StGntI);
    assign gnt_d = (fsm_q == StGntD);

    // Strobe of whichever master currently holds the grant.
    always_comb begin
        gnt_stb = 1'b0;
        if (gnt_i) begin
            gnt_stb = iwb_stb_i;
        end else if (gnt_d) begin
            gnt_stb = dwb_stb_i;
        end
    end

    // Watchdog fires only on a live request; an ack in the same cycle wins.
    assign wdog = (gnt_i | gnt_d) & gnt_stb & ~xwb_ack_i & (cnt_q == CntLim);

`ifdef AEMB_WBARB_RR_EN
    assign tie_to_d = (last_q == LastI);
`else
    // Fixed priority: dwb wins every tie; last_q is tracked but does not steer grants.
    logic unused_last;
    assign unused_last = last_q;
    assign tie_to_d    = 1'b1;
`endif

    // Slave-side request mux; everything is zero in IDLE.
    always_comb begin
        xwb_adr_o = '0;
        xwb_dat_o = '0;
        xwb_we_o  = 1'b0;
        if (gnt_d) begin
            xwb_adr_o = dwb_adr_i;
            xwb_dat_o = dwb_dat_i;
            xwb_we_o  = dwb_we_i;
        end else if (gnt_i) begin
            xwb_adr_o = iwb_adr_i;
        end
    end

    // The strobe is withdrawn in the watchdog cycle so the slave sees the abort.
    assign xwb_stb_o = gnt_stb & ~wdog;

    assign iwb_ack_o = gnt_i & xwb_ack_i;
    assign dwb_ack_o = gnt_d & xwb_ack_i;
    assign iwb_err_o = gnt_i & wdog;
    assign dwb_err_o = gnt_d & wdog;

    // Read data goes to both masters; only the acked one samples it.
    assign iwb_dat_o = xwb_dat_i;
    assign dwb_dat_o = xwb_dat_i;

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            fsm_q  <= StIdle;
            last_q <= LastI;
            cnt_q  <= 8'd0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (iwb_stb_i && dwb_stb_i) begin
                        cnt_q <= 8'd0;
                        if (tie_to_d) begin
                            fsm_q  <= StGntD;
                            last_q <= LastD;
                        end else begin
                            fsm_q  <= StGntI;
                            last_q <= LastI;
                        end
                    end else if (dwb_stb_i) begin
                        fsm_q  <= StGntD;
                        last_q <= LastD;
                        cnt_q  <= 8'd0;
                    end else if (iwb_stb_i) begin
                        fsm_q  <= StGntI;
                        last_q <= LastI;
                        cnt_q  <= 8'd0;
                    end
                end
                StGntI, StGntD: begin
                    // Ack, a dropped strobe, or a timeout all end the transaction.
                    if (xwb_ack_i || !gnt_stb || wdog) begin
                        fsm_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    fsm_q <= StIdle;
                end
            endcase
        end
    end

endmodule
